// File: rtl/overlap.sv
// Two-buffer overlap-add across LANES independent PCM lanes.
// A load fills BUF1 (clearing BUF2) or BUF2 in turn; action registers the per-lane wrapped sum.

module overlap_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             action,
  input  logic             half,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] buf1, buf2, sum;

  // Modulo-2^WIDTH add; signed and unsigned wrap are identical at this width.
  assign sum = buf1 + buf2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf1 <= '0;
      buf2 <= '0;
      dout <= '0;
    end else begin
      if (load) begin
        if (!half) begin
          buf1 <= din;
          buf2 <= '0;
        end else begin
          buf2 <= din;
        end
      end
      dout <= action ? sum : '0;
    end
  end

endmodule

module overlap #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   action,
  input  logic [WIDTH*LANES-1:0] dataBusIn,
  output logic [WIDTH*LANES-1:0] dataBusOut
);

  logic                        half;
  logic [LANES-1:0][WIDTH-1:0] din_l, dout_l;

  assign din_l      = dataBusIn;
  assign dataBusOut = dout_l;

  // Load toggles the target buffer; a bare action restarts the pair at BUF1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      half <= 1'b0;
    else if (load)   half <= ~half;
    else if (action) half <= 1'b0;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    overlap_lane #(.WIDTH(WIDTH)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .action (action),
      .half   (half),
      .din    (din_l[g]),
      .dout   (dout_l[g])
    );
  end

endmodule

// File: tb/tb_overlap.sv
// Randomized + directed bench for overlap; expected outputs queued by stimulus, checked by a monitor.

module tb_overlap;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        action = 1'b0;
  logic [63:0] dataBusIn = '0;
  logic [63:0] dataBusOut;

  overlap #(.WIDTH(16), .LANES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .action     (action),
    .dataBusIn  (dataBusIn),
    .dataBusOut (dataBusOut)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];

  // Reference state: two buffers of signed lane values and the load toggle.
  int m1[4];
  int m2[4];
  bit mhalf;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endfunction

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m1[k] = 0;
      m2[k] = 0;
    end
    mhalf = 1'b0;
  endfunction

  // One clock of stimulus: drive at the falling edge, queue the result the next rising edge must produce.
  task automatic cyc(input bit ld, input bit ac, input logic [63:0] d);
    logic [63:0] e;
    @(negedge clock);
    load = ld;
    action = ac;
    dataBusIn = d;
    e = '0;
    if (ac)
      for (int k = 0; k < 4; k++) e[k*16 +: 16] = 16'(m1[k] + m2[k]);
    exp_q.push_back(e);
    if (ld) begin
      for (int k = 0; k < 4; k++) begin
        if (!mhalf) begin
          m1[k] = int'($signed(d[k*16 +: 16]));
          m2[k] = 0;
        end else begin
          m2[k] = int'($signed(d[k*16 +: 16]));
        end
      end
      mhalf = ~mhalf;
    end else if (ac) begin
      mhalf = 1'b0;
    end
  endtask

  // Assert reset between clock edges and check the output clears without a clock.
  task automatic reset_pulse(input string name);
    @(negedge clock);
    load = 1'b0;
    action = 1'b0;
    #2 reset = 1'b0;
    #1 chk(name, dataBusOut, 64'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) chk("dataBusOut", dataBusOut, exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    #1 chk("reset_async", dataBusOut, 64'h0);
    repeat (2) @(posedge clock);
    #1 chk("reset_held", dataBusOut, 64'h0);
    @(negedge clock);
    reset = 1'b1;

    // single load then action: BUF2 was cleared
    cyc(1, 0, pk(1, 2, 3, 4));
    cyc(0, 1, 64'h0);
    cyc(0, 0, 64'h0);

    // pair sum, then next load restarts at BUF1
    cyc(1, 0, pk(100, -5, 0, 7));
    cyc(1, 0, pk(20, 5, -1, -7));
    cyc(0, 1, 64'h0);
    cyc(1, 0, pk(3, 3, 3, 3));
    cyc(0, 1, 64'h0);

    // wrap at both ends of the signed range
    cyc(1, 0, pk(32'h7FFF, 0, 0, 32'h8000));
    cyc(1, 0, pk(1, 0, 0, 32'hFFFF));
    cyc(0, 1, 64'h0);

    // simultaneous action and load
    cyc(1, 0, pk(10, 10, 10, 10));
    cyc(1, 0, pk(1, 1, 1, 1));
    cyc(1, 1, pk(50, 50, 50, 50));
    cyc(0, 1, 64'h0);

    // action after a half pair resets the toggle
    cyc(1, 0, pk(5, 6, 7, 8));
    cyc(0, 1, 64'h0);
    cyc(1, 0, pk(9, 9, 9, 9));
    cyc(0, 1, 64'h0);

    // asynchronous reset mid-pair discards everything
    cyc(1, 0, pk(11, 22, 33, 44));
    cyc(1, 0, pk(1, 2, 3, 4));
    cyc(0, 1, 64'h0);
    cyc(1, 0, pk(-7, 8, -9, 10));
    reset_pulse("reset_mid_pair");
    cyc(0, 1, 64'h0);
    cyc(1, 0, pk(12, -12, 300, -300));
    cyc(0, 1, 64'h0);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      if ($urandom_range(0, 99) == 0) reset_pulse("reset_random");
    end

    @(negedge clock);
    load = 1'b0;
    action = 1'b0;
    @(posedge clock);
    #2 chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
